// File: rtl/nn_pkg.sv
// Shared types and constants for the 2-2-1 network sequencer: op kinds, FSM
// states, step destinations, operand selects and the ReLU helper.
package nn_pkg;

   typedef enum logic {MUL = 1'b0, ADD = 1'b1} op_kind_e;

   typedef enum logic [1:0] {IDLE, ISSUE, WB} state_e;

   typedef enum logic [2:0] {P, Q, ACC, H1, H2, Y} dest_e;

   typedef enum logic [1:0] {A_WA, A_WB, A_P, A_ACC} a_sel_e;

   typedef enum logic [1:0] {B_IN0, B_IN1, B_Q, B_BIAS} b_sel_e;

   localparam int unsigned NN_STEPS      = 12;
   localparam int unsigned RELU_SIGN_BIT = 31;

   // Negative values, including -0, clamp to +0.
   function automatic logic [31:0] relu(input logic [31:0] v);
      return v[RELU_SIGN_BIT] ? '0 : v;
   endfunction

endpackage

// File: rtl/nn_step_decode.sv
// Step decoder: maps the 0..11 step index to op kind, operand selects,
// result destination and whether ReLU applies to the result.
module nn_step_decode
   import nn_pkg::*;
#(
   parameter bit OUT_RELU = 1'b0
) (
   input  logic [3:0] step,
   output op_kind_e   op_kind,
   output logic [1:0] neuron,
   output a_sel_e     a_sel,
   output b_sel_e     b_sel,
   output dest_e      dest,
   output logic       relu_en
);

   always_comb begin
      neuron  = step[3:2];
      op_kind = MUL;
      a_sel   = A_WA;
      b_sel   = B_IN0;
      dest    = P;
      relu_en = 1'b0;
      case (step[1:0])
         2'd0: begin
            op_kind = MUL;
         end
         2'd1: begin
            a_sel = A_WB;
            b_sel = B_IN1;
            dest  = Q;
         end
         2'd2: begin
            op_kind = ADD;
            a_sel   = A_P;
            b_sel   = B_Q;
            dest    = ACC;
         end
         default: begin
            op_kind = ADD;
            a_sel   = A_ACC;
            b_sel   = B_BIAS;
            case (step[3:2])
               2'd0: begin
                  dest    = H1;
                  relu_en = 1'b1;
               end
               2'd1: begin
                  dest    = H2;
                  relu_en = 1'b1;
               end
               default: begin
                  dest    = Y;
                  relu_en = OUT_RELU;
               end
            endcase
         end
      endcase
   end

endmodule

// File: rtl/nn_seq_ctrl.sv
// Sequencer for the 2-2-1 FP network: issues 12 MUL/ADD ops to a shared
// variable-latency FP unit, with a per-op watchdog and done/err status.
module nn_seq_ctrl
   import nn_pkg::*;
#(
   parameter int unsigned TIMEOUT  = 255,
   parameter bit          OUT_RELU = 1'b0
) (
   input  logic        clk,
   input  logic        rst_l,
   input  logic        start,
   input  logic [31:0] opA,
   input  logic [31:0] opB,
   input  logic [31:0] w11,
   input  logic [31:0] w12,
   input  logic [31:0] w21,
   input  logic [31:0] w22,
   input  logic [31:0] w31,
   input  logic [31:0] w32,
   input  logic [31:0] b1,
   input  logic [31:0] b2,
   input  logic [31:0] b3,
   output logic        op_req,
   output logic        op_kind,
   output logic [31:0] op_a,
   output logic [31:0] op_b,
   input  logic        op_ack,
   input  logic [31:0] op_res,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] y
);

   localparam int unsigned     WD_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT - 1);
   localparam logic [3:0]      LAST_STEP = 4'(NN_STEPS - 1);

   state_e          state, state_n;
   logic [3:0]      step;
   logic [WD_W-1:0] wdog;
   logic [31:0]     x0, x1, p, q, acc, h1, h2;
   logic            accept, capture, abort;

   op_kind_e        dec_kind;
   logic [1:0]      neuron;
   a_sel_e          a_sel;
   b_sel_e          b_sel;
   dest_e           dest;
   logic            relu_en;
   logic [31:0]     res_w;

   nn_step_decode #(.OUT_RELU(OUT_RELU)) u_dec (
      .step    (step),
      .op_kind (dec_kind),
      .neuron  (neuron),
      .a_sel   (a_sel),
      .b_sel   (b_sel),
      .dest    (dest),
      .relu_en (relu_en)
   );

   always_ff @(posedge clk) begin
      if (!rst_l) state <= IDLE;
      else        state <= state_n;
   end

   // A start landing in an abort's done cycle is dropped like one in WB.
   always_comb begin
      state_n = state;
      accept  = 1'b0;
      capture = 1'b0;
      abort   = 1'b0;
      case (state)
         IDLE: begin
            if (start && !done) begin
               accept  = 1'b1;
               state_n = ISSUE;
            end
         end
         ISSUE: begin
            if (op_ack) begin
               capture = 1'b1;
               state_n = WB;
            end else if (wdog == WD_LAST) begin
               abort   = 1'b1;
               state_n = IDLE;
            end
         end
         WB: begin
            state_n = (step == LAST_STEP) ? IDLE : ISSUE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      logic [31:0] wa, wb, bias, in0, in1, a_mux, b_mux;
      wa    = (neuron == 2'd0) ? w11 : (neuron == 2'd1) ? w21 : w31;
      wb    = (neuron == 2'd0) ? w12 : (neuron == 2'd1) ? w22 : w32;
      bias  = (neuron == 2'd0) ? b1  : (neuron == 2'd1) ? b2  : b3;
      in0   = (neuron == 2'd2) ? h1 : x0;
      in1   = (neuron == 2'd2) ? h2 : x1;
      a_mux = '0;
      b_mux = '0;
      case (a_sel)
         A_WA:    a_mux = wa;
         A_WB:    a_mux = wb;
         A_P:     a_mux = p;
         default: a_mux = acc;
      endcase
      case (b_sel)
         B_IN0:   b_mux = in0;
         B_IN1:   b_mux = in1;
         B_Q:     b_mux = q;
         default: b_mux = bias;
      endcase
      op_kind = op_req ? dec_kind : MUL;
      op_a    = op_req ? a_mux : '0;
      op_b    = op_req ? b_mux : '0;
      res_w   = relu_en ? relu(op_res) : op_res;
   end

   always_ff @(posedge clk) begin
      if (!rst_l) begin
         op_req <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
         y      <= '0;
         step   <= '0;
         wdog   <= '0;
         x0     <= '0;
         x1     <= '0;
         p      <= '0;
         q      <= '0;
         acc    <= '0;
         h1     <= '0;
         h2     <= '0;
      end else begin
         op_req <= (state_n == ISSUE);
         done   <= 1'b0;
         wdog   <= (state == ISSUE) ? wdog + 1'b1 : '0;
         if (accept) begin
            x0   <= opA;
            x1   <= opB;
            err  <= 1'b0;
            step <= '0;
            busy <= 1'b1;
         end
         if (state == WB && state_n == ISSUE) step <= step + 1'b1;
         // The final write lands on the ack edge so y, done and busy=0 share the WB cycle.
         if (capture) begin
            case (dest)
               P:   p   <= res_w;
               Q:   q   <= res_w;
               ACC: acc <= res_w;
               H1:  h1  <= res_w;
               H2:  h2  <= res_w;
               Y: begin
                  y    <= res_w;
                  done <= 1'b1;
                  busy <= 1'b0;
               end
               default: ;
            endcase
         end
         if (abort) begin
            err  <= 1'b1;
            done <= 1'b1;
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_nn_seq_ctrl.sv
// Scoreboard bench for nn_seq_ctrl: directed runs push expected results,
// a negedge monitor pops and compares on each done pulse.
module tb_nn_seq_ctrl;

   localparam logic [31:0] ONE  = 32'h3F800000;
   localparam logic [31:0] POS4 = 32'h40800000;
   localparam logic [31:0] NEG4 = 32'hC0800000;

   logic        clk = 1'b0;
   logic        rst_l = 1'b0;
   logic        start = 1'b0;
   logic [31:0] opA = '0, opB = '0;
   logic [31:0] w11 = POS4, w12 = POS4, w21 = NEG4, w22 = NEG4, w31 = POS4, w32 = POS4;
   logic [31:0] b1 = 32'hC0000000, b2 = 32'h40C00000, b3 = 32'hC0C00000;

   logic        op_req0, op_kind0, op_ack0 = 1'b0, busy0, done0, err0;
   logic [31:0] op_a0, op_b0, op_res0 = '0, y0;
   logic        op_req1, op_kind1, op_ack1 = 1'b0, busy1, done1, err1;
   logic [31:0] op_a1, op_b1, op_res1 = '0, y1;

   nn_seq_ctrl #(.TIMEOUT(255), .OUT_RELU(1'b0)) dut0 (
      .clk(clk), .rst_l(rst_l), .start(start), .opA(opA), .opB(opB),
      .w11(w11), .w12(w12), .w21(w21), .w22(w22), .w31(w31), .w32(w32),
      .b1(b1), .b2(b2), .b3(b3),
      .op_req(op_req0), .op_kind(op_kind0), .op_a(op_a0), .op_b(op_b0),
      .op_ack(op_ack0), .op_res(op_res0),
      .busy(busy0), .done(done0), .err(err0), .y(y0)
   );

   nn_seq_ctrl #(.TIMEOUT(255), .OUT_RELU(1'b1)) dut1 (
      .clk(clk), .rst_l(rst_l), .start(start), .opA(opA), .opB(opB),
      .w11(w11), .w12(w12), .w21(w21), .w22(w22), .w31(w31), .w32(w32),
      .b1(b1), .b2(b2), .b3(b3),
      .op_req(op_req1), .op_kind(op_kind1), .op_a(op_a1), .op_b(op_b1),
      .op_ack(op_ack1), .op_res(op_res1),
      .busy(busy1), .done(done1), .err(err1), .y(y1)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Integer-valued single-precision helpers for the FP unit model.
   function automatic int f2i(input logic [31:0] f);
      int e, m, v;
      if (f[30:0] == 31'd0) return 0;
      e = int'(f[30:23]) - 127;
      m = int'({1'b1, f[22:0]});
      v = (e >= 23) ? (m << (e - 23)) : (m >> (23 - e));
      return f[31] ? -v : v;
   endfunction

   function automatic logic [31:0] i2f(input int v);
      logic [31:0] a;
      logic        s;
      int          n;
      if (v == 0) return '0;
      s = (v < 0);
      a = s ? 32'(-v) : 32'(v);
      n = 0;
      for (int i = 0; i < 32; i++) if (a[i]) n = i;
      a = a << (23 - n);
      return {s, 8'(127 + n), a[22:0]};
   endfunction

   function automatic logic [31:0] fp_op(input logic kind, input logic [31:0] a, input logic [31:0] b);
      return kind ? i2f(f2i(a) + f2i(b)) : i2f(f2i(a) * f2i(b));
   endfunction

   int k = 0;
   int hang_idx = -1;
   int idx0 = 0, wait0 = 0, idx1 = 0, wait1 = 0;

   always @(posedge clk) begin
      #1;
      op_ack0 = 1'b0;
      if (!busy0) begin idx0 = 0; wait0 = 0; end
      if (op_req0 && idx0 != hang_idx) begin
         if (wait0 >= k) begin
            op_ack0 = 1'b1;
            op_res0 = fp_op(op_kind0, op_a0, op_b0);
            idx0++;
            wait0 = 0;
         end else wait0++;
      end
   end

   always @(posedge clk) begin
      #1;
      op_ack1 = 1'b0;
      if (!busy1) begin idx1 = 0; wait1 = 0; end
      if (op_req1 && idx1 != hang_idx) begin
         if (wait1 >= k) begin
            op_ack1 = 1'b1;
            op_res1 = fp_op(op_kind1, op_a1, op_b1);
            idx1++;
            wait1 = 0;
         end else wait1++;
      end
   end

   typedef struct {
      logic [31:0] y, y1, fa, fb;
      logic        err;
      int unsigned lat, nreq, hi, sc;
   } exp_t;

   typedef struct {
      logic [8*16-1:0] tag;
      logic            busy, op_req, done, err;
      logic [31:0]     y, op_a;
   } snap_t;

   exp_t  exp_q[$];
   snap_t snap_q[$];
   bit    fin = 1'b0;

   int unsigned n_checks = 0, n_pass = 0;

   task automatic check(input logic [8*16-1:0] tag, input string field,
                        input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act === expv) n_pass++;
      else $display("FAIL %0s.%s: got %0h expected %0h", tag, field, act, expv);
   endtask

   logic        prev_req = 1'b0, fk = 1'b0;
   logic [31:0] fa = '0, fb = '0;
   int unsigned nreq = 0, hi_run = 0, cur_run = 0;

   always @(negedge clk) begin
      exp_t  e;
      snap_t s;
      if (!rst_l) begin
         prev_req = 1'b0; nreq = 0; hi_run = 0; cur_run = 0;
      end else begin
         if (op_req0) begin
            if (!prev_req) begin
               nreq++;
               cur_run = 0;
               if (nreq == 1) begin fk = op_kind0; fa = op_a0; fb = op_b0; end
            end
            cur_run++;
            if (cur_run > hi_run) hi_run = cur_run;
         end
         prev_req = op_req0;
         if (done0) begin
            if (exp_q.size() == 0) check("run", "unexpected_done", 64'(done0), 64'd0);
            else begin
               e = exp_q.pop_front();
               check("run", "done1", 64'(done1), 64'd1);
               check("run", "y", 64'(y0), 64'(e.y));
               check("run", "y_relu", 64'(y1), 64'(e.y1));
               check("run", "err", 64'(err0), 64'(e.err));
               check("run", "err_relu", 64'(err1), 64'(e.err));
               check("run", "busy", 64'(busy0), 64'd0);
               check("run", "latency", 64'(cyc - e.sc), 64'(e.lat));
               check("run", "req_rises", 64'(nreq), 64'(e.nreq));
               check("run", "req_hi_max", 64'(hi_run), 64'(e.hi));
               check("run", "first_kind", 64'(fk), 64'd0);
               check("run", "first_ops", {fa, fb}, {e.fa, e.fb});
            end
            nreq = 0;
            hi_run = 0;
         end
      end
      if (snap_q.size() > 0) begin
         s = snap_q.pop_front();
         check(s.tag, "busy", 64'(busy0), 64'(s.busy));
         check(s.tag, "op_req", 64'(op_req0), 64'(s.op_req));
         check(s.tag, "done", 64'(done0), 64'(s.done));
         check(s.tag, "err", 64'(err0), 64'(s.err));
         check(s.tag, "y", 64'(y0), 64'(s.y));
         check(s.tag, "op_a", 64'(op_a0), 64'(s.op_a));
      end
      if (fin) begin
         check("end", "exp_q_left", 64'(exp_q.size()), 64'd0);
         $display("%0d/%0d checks passed", n_pass, n_checks);
         $finish;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push_exp(input logic [31:0] a, input logic [31:0] ey, input logic [31:0] ey1,
                           input logic eerr, input int unsigned elat, input int unsigned enreq,
                           input int unsigned ehi, input int unsigned sc);
      exp_t e;
      e.y = ey; e.y1 = ey1; e.err = eerr; e.lat = elat; e.nreq = enreq; e.hi = ehi;
      e.fa = w11; e.fb = a; e.sc = sc;
      exp_q.push_back(e);
   endtask

   task automatic push_snap(input logic [8*16-1:0] tag, input logic sb, input logic sr,
                            input logic sd, input logic se, input logic [31:0] sy);
      snap_t s;
      s.tag = tag; s.busy = sb; s.op_req = sr; s.done = sd; s.err = se; s.y = sy; s.op_a = '0;
      snap_q.push_back(s);
   endtask

   task automatic run(input logic [31:0] a, input logic [31:0] b, input int kk,
                      input logic [31:0] ey, input logic [31:0] ey1, input logic eerr,
                      input int unsigned elat, input int unsigned enreq, input int unsigned ehi);
      k = kk; opA = a; opB = b; start = 1'b1;
      push_exp(a, ey, ey1, eerr, elat, enreq, ehi, cyc);
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int unsigned limit);
      for (int unsigned i = 0; i < limit; i++) begin
         tick();
         if (done0) begin
            tick();
            return;
         end
      end
      push_snap("wait_done_tmo", 1'b0, 1'b0, 1'b1, 1'b0, '0);
      tick();
   endtask

   initial begin
      bit found;
      repeat (3) tick();
      push_snap("reset", 1'b0, 1'b0, 1'b0, 1'b0, '0);
      rst_l = 1'b1;
      tick();

      // x=(1,0), k=0: h1=2, h2=2, y=10
      run(ONE, '0, 0, 32'h41200000, 32'h41200000, 1'b0, 24, 12, 1);
      wait_done(100);

      // x=(1,1), k=3: h2 clamps, y=18
      run(ONE, ONE, 3, 32'h41900000, 32'h41900000, 1'b0, 60, 12, 4);
      wait_done(200);

      // start in the done cycle is dropped, the next cycle is accepted
      run(ONE, '0, 0, 32'h41200000, 32'h41200000, 1'b0, 24, 12, 1);
      repeat (23) tick();
      opA = ONE; opB = ONE; start = 1'b1;
      push_exp(ONE, 32'h41900000, 32'h41900000, 1'b0, 24, 12, 1, cyc + 1);
      tick();
      push_snap("done_cyc_start", 1'b0, 1'b0, 1'b0, 1'b0, 32'h41200000);
      tick();
      start = 1'b0;
      wait_done(100);

      // restart attempt and opA/opB rewrite while busy
      run(ONE, ONE, 1, 32'h41900000, 32'h41900000, 1'b0, 36, 12, 2);
      repeat (10) tick();
      opA = '0; opB = '0; start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(100);

      // FP unit never acks step 5: abort after 255 op_req cycles
      hang_idx = 5;
      run(ONE, '0, 0, 32'h41900000, 32'h41900000, 1'b1, 266, 6, 255);
      wait_done(400);
      hang_idx = -1;
      push_snap("err_sticky", 1'b0, 1'b0, 1'b0, 1'b1, 32'h41900000);
      tick();
      run(ONE, '0, 0, 32'h41200000, 32'h41200000, 1'b0, 24, 12, 1);
      wait_done(100);

      // reset pulse while step 7 is outstanding
      k = 2; opA = ONE; opB = '0; start = 1'b1;
      tick();
      start = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         if (op_req0 && idx0 == 7 && !op_ack0) found = 1'b1;
         else tick();
      end
      if (!found) push_snap("step7_tmo", 1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF);
      rst_l = 1'b0;
      tick();
      rst_l = 1'b1;
      push_snap("reset_midrun", 1'b0, 1'b0, 1'b0, 1'b0, '0);
      repeat (5) tick();
      run(ONE, '0, 0, 32'h41200000, 32'h41200000, 1'b0, 24, 12, 1);
      wait_done(100);

      // b3=-100: y=-84 without output ReLU, +0 with it
      b3 = 32'hC2C80000;
      run(ONE, '0, 0, 32'hC2A80000, 32'h00000000, 1'b0, 24, 12, 1);
      wait_done(100);
      b3 = 32'hC0C00000;

      repeat (3) tick();
      fin = 1'b1;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not reach the end");
      $fatal(1, "global timeout");
   end

endmodule
